// File: rtl/kernel_pr_srl_fifo_v2_if.sv
// Channel bundle for the kernel_pr shift-register FIFO: ap_fifo write/read handshake
// plus flush/error control and occupancy status.
interface kernel_pr_srl_fifo_v2_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 3
);

  logic                  if_write;
  logic                  if_write_ce;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read;
  logic                  if_read_ce;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic                  flush;
  logic                  err_clear;
  logic [CNT_WIDTH-1:0]  count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  err_overflow;
  logic                  err_underflow;

  // Producer/consumer side of the channel.
  modport master (
    output if_write,
    output if_write_ce,
    output if_din,
    output if_read,
    output if_read_ce,
    output flush,
    output err_clear,
    input  if_full_n,
    input  if_dout,
    input  if_empty_n,
    input  count,
    input  almost_full,
    input  almost_empty,
    input  err_overflow,
    input  err_underflow
  );

  // FIFO side of the channel.
  modport slave (
    input  if_write,
    input  if_write_ce,
    input  if_din,
    input  if_read,
    input  if_read_ce,
    input  flush,
    input  err_clear,
    output if_full_n,
    output if_dout,
    output if_empty_n,
    output count,
    output almost_full,
    output almost_empty,
    output err_overflow,
    output err_underflow
  );

endinterface

// File: rtl/kernel_pr_srl_fifo_v2.sv
// Shift-register FIFO with ap_fifo handshake, any depth >= 2, occupancy count,
// registered almost-full/empty flags, synchronous flush and sticky error flags.
module kernel_pr_srl_fifo_v2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned AF_THRESH  = 4,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  kernel_pr_srl_fifo_v2_if.slave io_fifo
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);

  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntAf   = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] CntAe   = CNT_WIDTH'(AE_THRESH);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_empty_n;
  logic                  r_full_n;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_err_overflow;
  logic                  r_err_underflow;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  w_count_d;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic                  w_err_overflow_d;
  logic                  w_err_underflow_d;
  logic [CNT_WIDTH-1:0]  w_count_m1;
  logic [ADDR_WIDTH-1:0] w_head_idx;

  assign w_wr_req = io_fifo.if_write & io_fifo.if_write_ce;
  assign w_rd_req = io_fifo.if_read & io_fifo.if_read_ce;
  // Handshake qualifies with the registered flags: no write-through when full.
  assign w_push   = w_wr_req & r_full_n;
  assign w_pop    = w_rd_req & r_empty_n;

  assign w_ovf_set = w_wr_req & ~r_full_n;
  assign w_unf_set = w_rd_req & ~r_empty_n;

  // Storage is not reset; only the occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_srl[0] <= io_fifo.if_din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_srl[i] <= r_srl[i-1];
      end
    end
  end

  always_comb begin
    w_count_d = r_count;
    if (io_fifo.flush) begin
      w_count_d = '0;
    end else if (w_push && !w_pop) begin
      w_count_d = r_count + CntOne;
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CntOne;
    end
  end

  // Setting a flag wins over clearing it in the same cycle.
  assign w_err_overflow_d  = w_ovf_set | (r_err_overflow & ~io_fifo.err_clear);
  assign w_err_underflow_d = w_unf_set | (r_err_underflow & ~io_fifo.err_clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count         <= '0;
      r_empty_n       <= 1'b0;
      r_full_n        <= 1'b1;
      r_almost_full   <= 1'b0;
      r_almost_empty  <= 1'b1;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_count         <= w_count_d;
      r_empty_n       <= (w_count_d != '0);
      r_full_n        <= (w_count_d != CntFull);
      r_almost_full   <= (w_count_d >= CntAf);
      r_almost_empty  <= (w_count_d <= CntAe);
      r_err_overflow  <= w_err_overflow_d;
      r_err_underflow <= w_err_underflow_d;
    end
  end

  // Newest word sits at SRL[0], so the head is at SRL[count-1].
  assign w_count_m1 = r_count - CntOne;
  assign w_head_idx = (r_count != '0) ? ADDR_WIDTH'(w_count_m1) : '0;

  assign io_fifo.if_dout       = r_srl[w_head_idx];
  assign io_fifo.if_empty_n    = r_empty_n;
  assign io_fifo.if_full_n     = r_full_n;
  assign io_fifo.count         = r_count;
  assign io_fifo.almost_full   = r_almost_full;
  assign io_fifo.almost_empty  = r_almost_empty;
  assign io_fifo.err_overflow  = r_err_overflow;
  assign io_fifo.err_underflow = r_err_underflow;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) r_count <= CntFull);
  a_empty_flag:  assert property (@(posedge clk) disable iff (reset)
                                  r_empty_n == (r_count != '0));
  a_full_flag:   assert property (@(posedge clk) disable iff (reset)
                                  r_full_n == (r_count != CntFull));

endmodule

// File: tb/tb_kernel_pr_srl_fifo_v2.sv
// Self-checking bench for kernel_pr_srl_fifo_v2: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_kernel_pr_srl_fifo_v2;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AF    = 4;
  localparam int unsigned AE    = 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  kernel_pr_srl_fifo_v2_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) fifo_if ();

  kernel_pr_srl_fifo_v2 #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_fifo (fifo_if.slave)
  );

  typedef struct {
    bit          rst, wr, wce, rd, rce, fl, clr;
    logic [7:0]  din;
    int          cnt;
    bit          en, fn, af, ae, ovf, unf;
    logic [7:0]  dout;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;

  function automatic vec_t mk(input int rst, wr, wce, rd, rce, fl, clr, din,
                              input int cnt, en, fn, af, ae, ovf, unf, dout);
    vec_t v;
    v.rst = (rst != 0); v.wr = (wr != 0); v.wce = (wce != 0); v.rd = (rd != 0);
    v.rce = (rce != 0); v.fl = (fl != 0); v.clr = (clr != 0); v.din = 8'(din);
    v.cnt = cnt; v.en = (en != 0); v.fn = (fn != 0); v.af = (af != 0);
    v.ae = (ae != 0); v.ovf = (ovf != 0); v.unf = (unf != 0); v.dout = 8'(dout);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour: a bounded queue with the ap_fifo acceptance rules.
  task automatic model_update(input bit rst, wr_req, rd_req, fl, clr, input logic [DW-1:0] din);
    int sz;
    bit ovs, uns, pu, po;
    sz  = mq.size();
    ovs = wr_req && (sz == int'(DEPTH));
    uns = rd_req && (sz == 0);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (fl) begin
        mq.delete();
      end else begin
        pu = wr_req && (sz < int'(DEPTH));
        po = rd_req && (sz > 0);
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back(din);
      end
      m_ovf = ovs | (m_ovf & !clr);
      m_unf = uns | (m_unf & !clr);
    end
  endtask

  task automatic apply(input bit rst, wr, wce, rd, rce, fl, clr, input logic [DW-1:0] din);
    reset               = rst;
    fifo_if.if_write    = wr;
    fifo_if.if_write_ce = wce;
    fifo_if.if_din      = din;
    fifo_if.if_read     = rd;
    fifo_if.if_read_ce  = rce;
    fifo_if.flush       = fl;
    fifo_if.err_clear   = clr;
    @(posedge clk);
    model_update(rst, wr & wce, rd & rce, fl, clr, din);
    cyc++;
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 32'(fifo_if.count), 32'(sz));
    chk({tag, ".empty_n"}, 32'(fifo_if.if_empty_n), 32'(sz != 0));
    chk({tag, ".full_n"}, 32'(fifo_if.if_full_n), 32'(sz != int'(DEPTH)));
    chk({tag, ".almost_full"}, 32'(fifo_if.almost_full), 32'(sz >= int'(AF)));
    chk({tag, ".almost_empty"}, 32'(fifo_if.almost_empty), 32'(sz <= int'(AE)));
    chk({tag, ".err_overflow"}, 32'(fifo_if.err_overflow), 32'(m_ovf));
    chk({tag, ".err_underflow"}, 32'(fifo_if.err_underflow), 32'(m_unf));
    if (sz > 0) chk({tag, ".dout"}, 32'(fifo_if.if_dout), 32'(mq[0]));
  endtask

  vec_t tbl[$];

  initial begin
    bit wr, rd, rst, fl, clr, wce, rce;
    int wr_pct;

    reset = 1'b1;
    fifo_if.if_write = 1'b0; fifo_if.if_write_ce = 1'b0; fifo_if.if_din = '0;
    fifo_if.if_read = 1'b0; fifo_if.if_read_ce = 1'b0;
    fifo_if.flush = 1'b0; fifo_if.err_clear = 1'b0;

    //                rst wr wce rd rce fl clr din    cnt en fn af ae ov un dout
    // Reset then fill
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h11,  1, 1, 1, 0, 1, 0, 0, 'h11));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h22,  2, 1, 1, 0, 0, 0, 0, 'h11));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h33,  3, 1, 1, 0, 0, 0, 0, 'h11));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h44,  4, 1, 1, 1, 0, 0, 0, 'h11));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h55,  5, 1, 0, 1, 0, 0, 0, 'h11));
    // Drain order
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  4, 1, 1, 1, 0, 0, 0, 'h22));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  3, 1, 1, 0, 0, 0, 0, 'h33));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  2, 1, 1, 0, 0, 0, 0, 'h44));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  1, 1, 1, 0, 1, 0, 0, 'h55));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    // Simultaneous push/pop at count 2
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h0A,  1, 1, 1, 0, 1, 0, 0, 'h0A));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h0B,  2, 1, 1, 0, 0, 0, 0, 'h0A));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 'h0C,  2, 1, 1, 0, 0, 0, 0, 'h0B));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 'h0D,  2, 1, 1, 0, 0, 0, 0, 'h0C));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 'h0E,  2, 1, 1, 0, 0, 0, 0, 'h0D));
    // Fill, then write+pop while full: write dropped
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h0F,  3, 1, 1, 0, 0, 0, 0, 'h0D));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h10,  4, 1, 1, 1, 0, 0, 0, 'h0D));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h12,  5, 1, 0, 1, 0, 0, 0, 'h0D));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 'h13,  4, 1, 1, 1, 0, 1, 0, 'h0E));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 'h00,  4, 1, 1, 1, 0, 1, 0, 'h0E));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  3, 1, 1, 0, 0, 1, 0, 'h0F));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  2, 1, 1, 0, 0, 1, 0, 'h10));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  1, 1, 1, 0, 1, 1, 0, 'h12));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  0, 0, 1, 0, 1, 1, 0, 'h00));
    // Underflow, clear, clear racing a new violation, clock-enable gating
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  0, 0, 1, 0, 1, 1, 1, 'h00));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 'h00,  0, 0, 1, 0, 1, 0, 1, 'h00));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 'h66,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    // Flush with push and pop in the same cycle
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h21,  1, 1, 1, 0, 1, 0, 0, 'h21));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h22,  2, 1, 1, 0, 0, 0, 0, 'h21));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h23,  3, 1, 1, 0, 0, 0, 0, 'h21));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 'h24,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h77,  1, 1, 1, 0, 1, 0, 0, 'h77));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 'h00,  0, 0, 1, 0, 1, 0, 0, 'h00));
    // Reset mid-operation with err_overflow set
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h31,  1, 1, 1, 0, 1, 0, 0, 'h31));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h32,  2, 1, 1, 0, 0, 0, 0, 'h31));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h33,  3, 1, 1, 0, 0, 0, 0, 'h31));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h34,  4, 1, 1, 1, 0, 0, 0, 'h31));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h35,  5, 1, 0, 1, 0, 0, 0, 'h31));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h36,  5, 1, 0, 1, 0, 1, 0, 'h31));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 'h37,  0, 0, 1, 0, 1, 0, 0, 'h00));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 'h99,  1, 1, 1, 0, 1, 0, 0, 'h99));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].wr, tbl[i].wce, tbl[i].rd, tbl[i].rce, tbl[i].fl,
            tbl[i].clr, tbl[i].din);
      chk("tbl.count", 32'(fifo_if.count), 32'(tbl[i].cnt));
      chk("tbl.empty_n", 32'(fifo_if.if_empty_n), 32'(tbl[i].en));
      chk("tbl.full_n", 32'(fifo_if.if_full_n), 32'(tbl[i].fn));
      chk("tbl.almost_full", 32'(fifo_if.almost_full), 32'(tbl[i].af));
      chk("tbl.almost_empty", 32'(fifo_if.almost_empty), 32'(tbl[i].ae));
      chk("tbl.err_overflow", 32'(fifo_if.err_overflow), 32'(tbl[i].ovf));
      chk("tbl.err_underflow", 32'(fifo_if.err_underflow), 32'(tbl[i].unf));
      if (tbl[i].en) chk("tbl.dout", 32'(fifo_if.if_dout), 32'(tbl[i].dout));
    end

    // Error checks stay live during flush: write at full and read at empty.
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      check_model("fill");
    end
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC8);
    chk("flush_full.err_overflow", 32'(fifo_if.err_overflow), 32'd1);
    chk("flush_full.count", 32'(fifo_if.count), 32'd0);
    check_model("flush_full");
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("flush_empty.err_underflow", 32'(fifo_if.err_underflow), 32'd1);
    check_model("flush_empty");
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check_model("clear");

    // Randomized traffic with alternating fill/drain bias.
    for (int c = 0; c < 4000; c++) begin
      wr_pct = ((c / 64) % 2 == 0) ? 75 : 25;
      wr  = ($urandom_range(0, 99) < wr_pct);
      rd  = ($urandom_range(0, 99) < (100 - wr_pct));
      wce = ($urandom_range(0, 7) != 0);
      rce = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 15) == 0);
      apply(rst, wr, wce, rd, rce, fl, clr, 8'($urandom));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
